// File: rtl/spi_mnrch_arb.sv
`default_nettype none
// ============================================================================
// Module   : spi_mnrch_arb
// Purpose  : Round-robin arbiter sharing one SPI_mnrch engine between two
//            requesters, with per-requester SS_n steering and a BUSY watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module spi_mnrch_arb #(
  parameter int TIMEOUT = 4096,
  parameter int GAP_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] cmd0,
  input  logic [15:0] cmd1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  resp0,
  output logic [7:0]  resp1,
  output logic        err0,
  output logic        err1,
  output logic        snd,
  output logic [15:0] cmd,
  input  logic        spi_done,
  input  logic [7:0]  spi_resp,
  input  logic        spi_SS_n,
  output logic        SS_n0,
  output logic        SS_n1,
  output logic        busy
);

  localparam int c_TW = $clog2(TIMEOUT);
  localparam int c_GW = $clog2(GAP_CYC + 1);
  localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT - 1);
  localparam logic [c_GW-1:0] c_GMAX = c_GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_spi_done_q;
  logic [c_TW-1:0]   r_timer;
  logic [c_GW-1:0]   r_gap_cnt;
  logic              r_prio;
  logic              r_sel;
  logic [15:0]       r_cmd;
  logic              r_snd;
  logic              r_done0;
  logic              r_done1;
  logic              r_err0;
  logic              r_err1;
  logic [7:0]        r_resp0;
  logic [7:0]        r_resp1;
  logic              r_busy;

  logic              w_rise;
  logic              w_grant;
  logic              w_winner;
  logic              w_complete;
  logic              w_timeout;
  logic              w_finish;

  // A done level left high by the previous transaction must not count; only
  // a fresh rising edge completes the current one.
  assign w_rise   = spi_done & ~r_spi_done_q;
  assign w_finish = w_complete | w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_winner    = r_prio;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req0 | req1) begin
          w_grant     = 1'b1;
          w_winner    = (req0 & req1) ? r_prio : req1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        // Completion takes precedence over a coincident watchdog expiry.
        if (w_rise) begin
          w_complete  = 1'b1;
          w_state_nxt = S_GAP;
        end else if (r_timer == c_TMAX) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == c_GMAX) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Launch path: winner selection, command capture and single-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snd        <= 1'b0;
      r_sel        <= 1'b0;
      r_cmd        <= 16'h0000;
      r_spi_done_q <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_snd        <= w_grant;
      r_spi_done_q <= spi_done;
      r_busy       <= (w_state_nxt != S_IDLE);
      if (w_grant) begin
        r_sel <= w_winner;
        r_cmd <= w_winner ? cmd1 : cmd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer   <= '0;
      r_gap_cnt <= '0;
    end else begin
      if (w_grant) begin
        r_timer <= '0;
      end else if ((r_state == S_BUSY) && (w_state_nxt == S_BUSY)) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_finish) begin
        r_gap_cnt <= '0;
      end else if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end
    end
  end

  // Return path: per-requester done/err pulses, held response and priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
      r_resp0 <= 8'h00;
      r_resp1 <= 8'h00;
      r_prio  <= 1'b0;
    end else begin
      r_done0 <= w_finish & ~r_sel;
      r_done1 <= w_finish & r_sel;
      r_err0  <= w_timeout & ~r_sel;
      r_err1  <= w_timeout & r_sel;
      if (w_finish) begin
        r_prio <= ~r_sel;
        if (r_sel) begin
          r_resp1 <= w_complete ? spi_resp : 8'hFF;
        end else begin
          r_resp0 <= w_complete ? spi_resp : 8'hFF;
        end
      end
    end
  end

  assign snd   = r_snd;
  assign cmd   = r_cmd;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign err0  = r_err0;
  assign err1  = r_err1;
  assign resp0 = r_resp0;
  assign resp1 = r_resp1;
  assign busy  = r_busy;

  assign SS_n0 = r_sel ? 1'b1 : spi_SS_n;
  assign SS_n1 = r_sel ? spi_SS_n : 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_spi_mnrch_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_mnrch_arb
// Purpose  : Randomized self-checking bench for spi_mnrch_arb against an
//            event-level reference model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_mnrch_arb;

  localparam int c_T = 48;
  localparam int c_G = 4;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] cmd0, cmd1;
  logic        done0, done1;
  logic [7:0]  resp0, resp1;
  logic        err0, err1;
  logic        snd;
  logic [15:0] cmd;
  logic        spi_done;
  logic [7:0]  spi_resp;
  logic        spi_SS_n;
  logic        SS_n0, SS_n1;
  logic        busy;

  spi_mnrch_arb #(.TIMEOUT(c_T), .GAP_CYC(c_G)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .done0(done0), .done1(done1), .resp0(resp0), .resp1(resp1),
    .err0(err0), .err1(err1), .snd(snd), .cmd(cmd),
    .spi_done(spi_done), .spi_resp(spi_resp), .spi_SS_n(spi_SS_n),
    .SS_n0(SS_n0), .SS_n1(SS_n1), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int c     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, c, got, exp);
    end
  endtask

  // Reference model: one outstanding job, launch allowed from m_free_at on.
  logic        m_busy, m_prio, m_sel, w;
  logic [15:0] m_cmd;
  logic [7:0]  m_resp [2];
  int          m_g, m_free_at;
  logic        granted [2];
  logic        e_snd, rise, sd_prev;
  logic [1:0]  e_done, e_err;
  int          sp_clear, sp_rise, pick;
  logic [7:0]  sp_resp;
  logic        first_txn, did_rst, hold_all;

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_snd"},   snd,   1'b0);
    chk({pfx, "_cmd"},   cmd,   16'h0000);
    chk({pfx, "_done0"}, done0, 1'b0);
    chk({pfx, "_done1"}, done1, 1'b0);
    chk({pfx, "_err0"},  err0,  1'b0);
    chk({pfx, "_err1"},  err1,  1'b0);
    chk({pfx, "_resp0"}, resp0, 8'h00);
    chk({pfx, "_resp1"}, resp1, 8'h00);
    chk({pfx, "_busy"},  busy,  1'b0);
    chk({pfx, "_ss0"},   SS_n0, spi_SS_n);
    chk({pfx, "_ss1"},   SS_n1, 1'b1);
  endtask

  task automatic model_clear();
    m_busy = 1'b0; m_prio = 1'b0; m_sel = 1'b0; m_cmd = 16'h0000;
    m_resp[0] = 8'h00; m_resp[1] = 8'h00;
    granted[0] = 1'b0; granted[1] = 1'b0;
    sp_clear = -1; sp_rise = -1; sd_prev = 1'b0;
  endtask

  task automatic drive_requester(input int n);
    logic r;
    r = (n == 0) ? req0 : req1;
    if (e_done[n]) begin
      granted[n] = 1'b0;
      if (!hold_all && ($urandom_range(0, 1) == 0)) r = 1'b0;
      else if (n == 0) cmd0 = 16'($urandom);
      else cmd1 = 16'($urandom);
    end else if (!r) begin
      if (hold_all || ($urandom_range(0, 3) == 0)) begin
        r = 1'b1;
        if (n == 0) cmd0 = 16'($urandom);
        else cmd1 = 16'($urandom);
      end
    end else if (!granted[n] && !hold_all && ($urandom_range(0, 63) == 0)) begin
      r = 1'b0;
    end
    if (n == 0) req0 = r;
    else req1 = r;
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; cmd0 = 16'h0; cmd1 = 16'h0;
    spi_done = 1'b0; spi_resp = 8'h00; spi_SS_n = 1'b1;
    model_clear();
    first_txn = 1'b1; did_rst = 1'b0; hold_all = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    req0 = 1'b1; cmd0 = 16'h0D02;
    rst_n = 1'b1;
    c = 0; m_free_at = 1;

    for (int it = 0; it < 6000; it++) begin
      @(negedge clk);
      c++;
      hold_all = (c >= 1500) && (c < 2400);

      e_snd = 1'b0; e_done = 2'b00; e_err = 2'b00;
      if (!m_busy && (c >= m_free_at) && (req0 || req1)) begin
        w = (req0 && req1) ? m_prio : req1;
        m_busy = 1'b1; m_g = c; m_sel = w;
        m_cmd = w ? cmd1 : cmd0;
        granted[w] = 1'b1;
        e_snd = 1'b1;
      end else if (m_busy && (c > m_g)) begin
        rise = spi_done && !sd_prev;
        if (rise || (c == m_g + c_T)) begin
          e_done[m_sel] = 1'b1;
          if (rise) m_resp[m_sel] = spi_resp;
          else begin
            e_err[m_sel] = 1'b1;
            m_resp[m_sel] = 8'hFF;
          end
          m_busy = 1'b0; m_prio = !m_sel;
          m_free_at = c + c_G + 1;
        end
      end

      chk("snd",   snd,   e_snd);
      chk("cmd",   cmd,   m_cmd);
      chk("done0", done0, e_done[0]);
      chk("done1", done1, e_done[1]);
      chk("err0",  err0,  e_err[0]);
      chk("err1",  err1,  e_err[1]);
      chk("resp0", resp0, m_resp[0]);
      chk("resp1", resp1, m_resp[1]);
      chk("busy",  busy,  (m_busy || (c < m_free_at - 1)));
      chk("ss0",   SS_n0, (m_sel == 1'b0) ? spi_SS_n : 1'b1);
      chk("ss1",   SS_n1, (m_sel == 1'b1) ? spi_SS_n : 1'b1);

      if ((c >= 2500) && !did_rst && m_busy && (c > m_g + 2)) begin
        // Asynchronous reset in the middle of a live transaction.
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        model_clear();
        spi_done = 1'b0; spi_SS_n = 1'b1;
        req0 = 1'b1; req1 = 1'b0; cmd0 = 16'($urandom);
        repeat (3) begin
          @(negedge clk);
          c++;
        end
        rst_n = 1'b1;
        m_free_at = c + 1;
        did_rst = 1'b1;
      end else begin
        sd_prev = spi_done;
        if (e_snd) begin
          sp_clear = c + 1 + int'($urandom_range(0, 1));
          pick = int'($urandom_range(0, 15));
          sp_resp = 8'($urandom);
          if (first_txn) begin
            sp_rise = c + 40; sp_resp = 8'h5A; first_txn = 1'b0;
          end else if (pick == 0) sp_rise = -1;
          else if (pick == 1) sp_rise = c + c_T;
          else if (pick == 2) sp_rise = c + c_T + 1;
          else sp_rise = c + int'($urandom_range(4, 40));
        end
        if (c + 1 == sp_clear) begin
          spi_done = 1'b0; spi_SS_n = 1'b0;
        end
        if (c + 1 == sp_rise) begin
          spi_done = 1'b1; spi_SS_n = 1'b1; spi_resp = sp_resp;
        end
        drive_requester(0);
        if (c > 100) drive_requester(1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_mnrch_arb.md
Name: spi_mnrch_arb

Overview:
- Shares one SPI_mnrch transaction engine between two requesters, e.g. port 0 = inert_intf SM and port 1 = A2D/IR-sensor sequencer.
- Picks a requester with round-robin arbitration, launches its 16-bit cmd, waits for completion, and returns resp to the winner.
- Demuxes SS_n per requester.
- Watchdog aborts hung transactions so neither requester deadlocks.

Parameters:
- TIMEOUT, 4096: max clk cycles in BUSY before abort (≥2).
- GAP_CYC, 4: idle cycles after each transaction before the next launch (SS_n high time, ≥1).

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- req0, req1  in  1  level request; hold until matching done pulse
- cmd0, cmd1  in  16  command from each requester; sampled at grant
- done0, done1  out  1  one-clk pulse, transaction finished for that requester
- resp0, resp1  out  8  response byte; valid with and held after doneN
- err0, err1  out  1  one-clk pulse, coincident with doneN on timeout
- snd  out  1  one-clk launch strobe to SPI_mnrch
- cmd  out  16  command to SPI_mnrch; stable from snd through completion
- spi_done  in  1  SPI_mnrch done: level, set on completion, cleared after snd
- spi_resp  in  8  SPI_mnrch resp
- spi_SS_n  in  1  SS_n from SPI_mnrch
- SS_n0, SS_n1  out  1  per-requester selects
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: snd=0, cmd=0, done*=0, err*=0, resp*=0, sel=0, prio=0 (req0 favoured), state=IDLE, counters=0, spi_done_q=0.
- All outputs are registered except SS_n0/SS_n1.
- Steering: SS_nX = spi_SS_n when sel==X, else 1.
- States: IDLE, BUSY, GAP.
- IDLE:
  - No req: stay.
  - One req: grant it.
  - Both req: grant the one indicated by prio.
  - On grant (sampled cycle t): sel<=winner, cmd<=cmdN, snd=1 in cycle t+1 only, go BUSY, clear timer.
  - A req dropped before it is sampled is never serviced.
- BUSY:
  - Completion is a rising edge of spi_done (spi_done & ~spi_done_q). A level high stale from the previous transaction does not complete.
  - On completion: respN<=spi_resp and doneN=1 for the next cycle. prio<=other requester. Go GAP, clear gap counter.
  - req levels are ignored while BUSY; cmd holds.
  - Timer counts every BUSY cycle. When the timer reaches TIMEOUT-1 without completion: doneN=1 and errN=1 next cycle, respN<=8'hFF, prio flips, go GAP.
  - If completion and timeout fall in the same cycle, completion wins (err=0, real resp).
- GAP: count GAP_CYC cycles, then IDLE. Requests arriving during GAP wait.
- Requester contract: after doneN, deassert reqN or keep it high to request again. Keeping it high earns a fresh grant only after GAP, and only if the other requester is idle or it holds prio.
  - Minimum launch-to-launch for one requester is 1 (grant→snd) + transaction + 1 + GAP_CYC.
- Starvation bound: with both requesting continuously, grants strictly alternate 0,1,0,1…
- Reset mid-operation: all outputs return to reset values asynchronously. No doneN is issued for the aborted transaction; the requester restarts after reset.
- snd is never asserted outside the cycle following a grant; at most one outstanding transaction.
- busy = (state != IDLE).

Test Plan:
- Single request: req0=1, cmd0=16'h0D02; model raises spi_done 40 cycles after snd with spi_resp=8'h5A. Expect:
  - snd one cycle after req sampled, cmd=0D02, SS_n1 stays 1.
  - done0 pulse one cycle after spi_done rise, resp0=5A, err0=0, done1 never.
- Simultaneous requests: req0 and req1 high together from reset, cmd0=A6xx, cmd1=1234. Expect:
  - Grant order 0,1,0,1 across 4 transactions.
  - Each cmd matches the winner; GAP_CYC≥4 idle cycles between launches.
- Stale done: spi_done held high before the grant, drops 2 cycles after snd, rises at +30. Expect exactly one done pulse, at the +30 rise, not at launch.
- Timeout: TIMEOUT=16, req1 granted, spi_done never rises. Expect done1=err1=1 on one cycle 16 cycles after entering BUSY, resp1=FF, then req0 serviceable after GAP.
- Completion/timeout tie: spi_done rises exactly on cycle TIMEOUT-1. Expect done=1, err=0, resp=spi_resp.
- Reset mid-BUSY: assert rst_n=0 while BUSY. Expect immediately snd=0, cmd=0, SS_n0=SS_n1 follow spi_SS_n/1 per sel=0, busy=0, no done pulse. After release, a held req0 is granted normally.
